instr_inv_multi_queue: RTL and testbench
========================================

Name: instr_inv_multi_queue

Overview:
- Parametrised invalidation queue between the coherency snoop path and the instruction-side consumers (icache, branch predictor, further consumers).
- Successor to the fixed single-depth invalidation buffer sized by INSTR_INV_QUEUE_DEPTH. Adds N-consumer broadcast with per-consumer acknowledge, back-to-back duplicate coalescing, and overflow recovery through a flush-all request instead of loss.
- Never back-pressures the snoop source.

Parameters:
DEPTH, 4, queue entries; power of 2, >=2
ADDR_W, 28, line-address width of an invalidation
NUM_CONSUMERS, 2, number of consumers that must each acknowledge every entry
COALESCE, 1, 1 = drop an input equal to the youngest queued entry

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
inv_valid  in  1  invalidation request; always accepted
inv_addr  in  ADDR_W  line address
cons_valid  out  NUM_CONSUMERS  per-consumer request valid
cons_addr  out  ADDR_W  head entry address (shared)
cons_flush_all  out  1  head request is flush-all; cons_addr is don't-care
cons_ack  in  NUM_CONSUMERS  per-consumer completion; counts only when matching cons_valid is high
empty  out  1  no queued entry and no flush pending (fence.i ordering)
overflow_count  out  8  saturating count of overflow events

Behaviour:
- Reset, asynchronous: count=0, head/tail pointers=0, done mask=0, flush_pending=0, overflow_count=0.
- Output values during reset: cons_valid=0, cons_flush_all=0, cons_addr=0, empty=1.
- Storage is a circular buffer. Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Head request selection: flush_pending has priority over queued entries.
  - Head is the flush-all request if flush_pending=1.
  - Otherwise head is buf[head] if count!=0.
- Output logic:
  - cons_valid[i] = head_exists & ~done[i]. Combinational from registered state only; no combinational path from cons_ack or inv_* to outputs.
  - cons_flush_all = flush_pending.
- Acknowledge:
  - cons_ack[i] & cons_valid[i] sets done[i].
  - complete = &(done | (cons_ack & cons_valid)).
  - On complete, the head retires and done clears. If the flush-all request retires, flush_pending clears; otherwise head++ and count--.
  - The next head appears on cons_valid the following cycle; minimum 1 cycle per entry.
  - Acks from different consumers may arrive in any cycles and in any order. Acks with cons_valid low are ignored.
- Coalesce (COALESCE=1): inv_valid is dropped with no state change when all of the following hold:
  - count!=0;
  - inv_addr == buf[tail-1];
  - that entry is not the head with done!=0, i.e. a partially serviced head is never coalesced onto.
- Push: an inv_valid that is not coalesced writes buf[tail], then tail++ and count++.
- Full test: full = (count==DEPTH) & ~(pop this cycle). A same-cycle pop frees the slot, so the push succeeds.
- Overflow (push while full):
  - All queued entries are discarded: count=0, head=tail.
  - flush_pending=1, done=0 (restarts a flush already in progress).
  - overflow_count increments, saturating at 255.
  - The incoming address is not stored; flush-all covers it.
- Pushes during flush_pending enqueue normally. They are serviced after the flush retires, so no invalidation issued after a consumer's flush ack is lost.
- Pop and push in the same cycle: count unchanged, both pointers advance.
- empty = (count==0) & ~flush_pending, registered-state based.

Test Plan:
- DEPTH=4, N=2. Push 0x10, 0x20. Ack c0 at cycle t, c1 at t+2 → head stays 0x10 with cons_valid=01 until c1 ack; at t+3 cons_addr=0x20, cons_valid=11; count 2→1→0; empty rises after the final ack.
- COALESCE=1. Push 0x30 twice back-to-back → count=1. Push 0x30 after c0 has acked the head (done=01) → count=2.
- Push 5 distinct addresses with no acks → on the 5th: count=0, cons_flush_all=1, cons_valid=11, overflow_count=1. Push 0x40 during flush, then ack both → cons_flush_all drops and the next head is 0x40.
- Full queue, all consumers ack the head in the same cycle as a push of 0x50 → no overflow; count stays 4; 0x50 is at the tail.
- Assert rst while an entry is half-acknowledged → outputs immediately go to cons_valid=0, empty=1, overflow_count=0; after release, a new push is presented normally.
- 300 overflow events → overflow_count saturates at 255.

Source files
------------

// File: rtl/instr_inv_multi_queue_if.sv
// Bundles the snoop-side push and the consumer-side broadcast/acknowledge
// signals of instr_inv_multi_queue.
//   inv_valid/inv_addr : invalidation push from the snoop path (never stalled)
//   cons_valid         : per-consumer request valid
//   cons_addr          : shared head line address
//   cons_flush_all     : head request is a flush-all
//   cons_ack           : per-consumer completion
//   empty              : nothing queued and no flush pending
//   overflow_count     : saturating overflow event count
interface instr_inv_multi_queue_if #(
  parameter int unsigned ADDR_W        = 28,
  parameter int unsigned NUM_CONSUMERS = 2
);
  logic                     inv_valid;
  logic [ADDR_W-1:0]        inv_addr;
  logic [NUM_CONSUMERS-1:0] cons_valid;
  logic [ADDR_W-1:0]        cons_addr;
  logic                     cons_flush_all;
  logic [NUM_CONSUMERS-1:0] cons_ack;
  logic                     empty;
  logic [7:0]               overflow_count;

  // Snoop source and consumers drive requests/acks.
  modport master (
    output inv_valid, inv_addr, cons_ack,
    input  cons_valid, cons_addr, cons_flush_all, empty, overflow_count
  );

  // Queue side.
  modport slave (
    input  inv_valid, inv_addr, cons_ack,
    output cons_valid, cons_addr, cons_flush_all, empty, overflow_count
  );
endinterface

// File: rtl/instr_inv_multi_queue.sv
// Invalidation queue between the coherency snoop path and instruction-side
// consumers. Every entry is broadcast to NUM_CONSUMERS consumers and retires
// once each has acknowledged it. Back-to-back duplicates are coalesced, and an
// overflow discards the queue in favour of a single flush-all request.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : instr_inv_multi_queue_if.slave (push, broadcast, ack, status)
module instr_inv_multi_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ADDR_W        = 28,
  parameter int unsigned NUM_CONSUMERS = 2,
  parameter int unsigned COALESCE      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_inv_multi_queue_if.slave  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned N     = NUM_CONSUMERS;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [N-1:0]      done_q, done_d;
  logic              flush_q, flush_d;
  logic [7:0]        ovf_q, ovf_d;

  logic              head_exists;
  logic [N-1:0]      valid_vec;
  logic [N-1:0]      ack_v;
  logic              complete;
  logic              pop_entry;
  logic              head_is_youngest;
  logic              coalesce;
  logic              push;
  logic              full;
  logic              overflow;
  logic              push_ok;

  // Request presentation, derived from registered state only.
  assign head_exists = flush_q | (count_q != '0);
  assign valid_vec   = {N{head_exists}} & ~done_q;

  assign bus.cons_valid     = valid_vec;
  assign bus.cons_flush_all = flush_q;
  assign bus.cons_addr      = (count_q != '0) ? mem_q[head_q] : '0;
  assign bus.empty          = (count_q == '0) & ~flush_q;
  assign bus.overflow_count = ovf_q;

  // Acknowledge and retirement.
  assign ack_v     = bus.cons_ack & valid_vec;
  assign complete  = head_exists & (&(done_q | ack_v));
  assign pop_entry = complete & ~flush_q;

  // The youngest entry is the serviced head only when it is the sole entry
  // and no flush sits in front of it.
  assign head_is_youngest = ~flush_q & (count_q == CNT_W'(1));
  assign coalesce = (COALESCE != 0) & bus.inv_valid & (count_q != '0)
                  & (bus.inv_addr == mem_q[tail_q - PTR_W'(1)])
                  & ~(head_is_youngest & (done_q != '0));

  // A same-cycle entry pop frees a slot, so only a non-popping full queue overflows.
  assign push     = bus.inv_valid & ~coalesce;
  assign full     = (count_q == CNT_W'(DEPTH)) & ~pop_entry;
  assign overflow = push & full;
  assign push_ok  = push & ~full;

  // Next-state computation.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q;
    flush_d = flush_q;
    ovf_d   = ovf_q;
    if (overflow) begin
      // Drop everything queued; a (re)started flush-all covers it all.
      count_d = '0;
      head_d  = tail_q;
      flush_d = 1'b1;
      done_d  = '0;
      if (ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end else begin
      if (complete) begin
        done_d = '0;
        if (flush_q) flush_d = 1'b0;
        else         head_d  = head_q + PTR_W'(1);
      end else begin
        done_d = done_q | ack_v;
      end
      if (push_ok) tail_d = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_entry);
    end
  end

  // Control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
      flush_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage; contents are only read while count_q covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= bus.inv_addr;
  end

endmodule

// File: tb/tb_instr_inv_multi_queue.sv
// Directed bench for instr_inv_multi_queue (DEPTH=4, two consumers, coalescing on).
module tb_instr_inv_multi_queue;

  localparam int unsigned ADDR_W  = 28;
  localparam int unsigned NC      = 2;
  localparam int unsigned WDOG_CY = 50000;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [ADDR_W-1:0] a;

  instr_inv_multi_queue_if #(.ADDR_W(ADDR_W), .NUM_CONSUMERS(NC)) ifc ();

  instr_inv_multi_queue #(
    .DEPTH(4), .ADDR_W(ADDR_W), .NUM_CONSUMERS(NC), .COALESCE(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of stimulus, then return inputs to idle.
  task automatic drive(input logic v, input logic [ADDR_W-1:0] addr, input logic [NC-1:0] ack);
    ifc.inv_valid = v;
    ifc.inv_addr  = addr;
    ifc.cons_ack  = ack;
    tick();
    ifc.inv_valid = 1'b0;
    ifc.cons_ack  = '0;
  endtask

  // Watchdog on the whole directed sequence.
  initial begin
    repeat (WDOG_CY) @(posedge clk);
    n_fail++;
    $error("FAIL timeout: sequence did not finish within %0d cycles", WDOG_CY);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    ifc.inv_valid = 1'b0;
    ifc.inv_addr  = '0;
    ifc.cons_ack  = '0;
    tick();
    tick();
    chk("rst_valid", 32'(ifc.cons_valid), 32'h0);
    chk("rst_flush", 32'(ifc.cons_flush_all), 32'h0);
    chk("rst_addr", 32'(ifc.cons_addr), 32'h0);
    chk("rst_empty", 32'(ifc.empty), 32'h1);
    chk("rst_ovf", 32'(ifc.overflow_count), 32'h0);
    rst = 1'b0;
    tick();

    // Split acknowledge: c0 first, c1 two cycles later.
    drive(1'b1, 28'h10, 2'b00);
    drive(1'b1, 28'h20, 2'b00);
    chk("t1_valid0", 32'(ifc.cons_valid), 32'h3);
    chk("t1_addr0", 32'(ifc.cons_addr), 32'h10);
    chk("t1_count2", 32'(dut.count_q), 32'd2);
    chk("t1_nempty", 32'(ifc.empty), 32'h0);
    drive(1'b0, 28'h0, 2'b01);
    chk("t1_half_valid", 32'(ifc.cons_valid), 32'h2);
    chk("t1_half_addr", 32'(ifc.cons_addr), 32'h10);
    drive(1'b0, 28'h0, 2'b00);
    chk("t1_hold_valid", 32'(ifc.cons_valid), 32'h2);
    chk("t1_hold_count", 32'(dut.count_q), 32'd2);
    drive(1'b0, 28'h0, 2'b10);
    chk("t1_next_addr", 32'(ifc.cons_addr), 32'h20);
    chk("t1_next_valid", 32'(ifc.cons_valid), 32'h3);
    chk("t1_count1", 32'(dut.count_q), 32'd1);
    chk("t1_nempty2", 32'(ifc.empty), 32'h0);
    drive(1'b0, 28'h0, 2'b11);
    chk("t1_count0", 32'(dut.count_q), 32'd0);
    chk("t1_empty", 32'(ifc.empty), 32'h1);
    chk("t1_idle_valid", 32'(ifc.cons_valid), 32'h0);

    // Coalescing of back-to-back duplicates, but not onto a partly acked head.
    drive(1'b1, 28'h30, 2'b00);
    drive(1'b1, 28'h30, 2'b00);
    chk("t2_coalesced", 32'(dut.count_q), 32'd1);
    drive(1'b0, 28'h0, 2'b01);
    drive(1'b1, 28'h30, 2'b00);
    chk("t2_not_coalesced", 32'(dut.count_q), 32'd2);
    chk("t2_valid", 32'(ifc.cons_valid), 32'h2);
    drive(1'b0, 28'h0, 2'b10);
    chk("t2_second_valid", 32'(ifc.cons_valid), 32'h3);
    chk("t2_second_addr", 32'(ifc.cons_addr), 32'h30);
    chk("t2_count1", 32'(dut.count_q), 32'd1);
    drive(1'b0, 28'h0, 2'b11);
    chk("t2_empty", 32'(ifc.empty), 32'h1);

    // Overflow converts the queue into a flush-all; later pushes queue behind it.
    for (int i = 1; i <= 4; i++) drive(1'b1, ADDR_W'(i), 2'b00);
    chk("t3_full", 32'(dut.count_q), 32'd4);
    drive(1'b1, 28'h5, 2'b00);
    chk("t3_count0", 32'(dut.count_q), 32'd0);
    chk("t3_flush", 32'(ifc.cons_flush_all), 32'h1);
    chk("t3_valid", 32'(ifc.cons_valid), 32'h3);
    chk("t3_ovf", 32'(ifc.overflow_count), 32'd1);
    chk("t3_nempty", 32'(ifc.empty), 32'h0);
    drive(1'b1, 28'h40, 2'b00);
    chk("t3_push_in_flush", 32'(dut.count_q), 32'd1);
    chk("t3_flush_hold", 32'(ifc.cons_flush_all), 32'h1);
    drive(1'b0, 28'h0, 2'b11);
    chk("t3_flush_done", 32'(ifc.cons_flush_all), 32'h0);
    chk("t3_next_addr", 32'(ifc.cons_addr), 32'h40);
    chk("t3_next_valid", 32'(ifc.cons_valid), 32'h3);
    drive(1'b0, 28'h0, 2'b11);
    chk("t3_empty", 32'(ifc.empty), 32'h1);

    // Full queue with a same-cycle pop and push: no overflow.
    for (int i = 0; i < 4; i++) drive(1'b1, ADDR_W'(32'h61 + i), 2'b00);
    chk("t4_full", 32'(dut.count_q), 32'd4);
    drive(1'b1, 28'h50, 2'b11);
    chk("t4_no_ovf", 32'(ifc.overflow_count), 32'd1);
    chk("t4_count4", 32'(dut.count_q), 32'd4);
    chk("t4_no_flush", 32'(ifc.cons_flush_all), 32'h0);
    chk("t4_head", 32'(ifc.cons_addr), 32'h62);
    drive(1'b0, 28'h0, 2'b11);
    chk("t4_head63", 32'(ifc.cons_addr), 32'h63);
    drive(1'b0, 28'h0, 2'b11);
    chk("t4_head64", 32'(ifc.cons_addr), 32'h64);
    drive(1'b0, 28'h0, 2'b11);
    chk("t4_tail50", 32'(ifc.cons_addr), 32'h50);
    drive(1'b0, 28'h0, 2'b11);
    chk("t4_empty", 32'(ifc.empty), 32'h1);

    // Asynchronous reset while the head is half acknowledged.
    drive(1'b1, 28'h70, 2'b00);
    drive(1'b0, 28'h0, 2'b01);
    chk("t5_half", 32'(ifc.cons_valid), 32'h2);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(ifc.cons_valid), 32'h0);
    chk("t5_rst_empty", 32'(ifc.empty), 32'h1);
    chk("t5_rst_ovf", 32'(ifc.overflow_count), 32'h0);
    chk("t5_rst_addr", 32'(ifc.cons_addr), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    drive(1'b1, 28'h80, 2'b00);
    chk("t5_post_valid", 32'(ifc.cons_valid), 32'h3);
    chk("t5_post_addr", 32'(ifc.cons_addr), 32'h80);
    drive(1'b0, 28'h0, 2'b11);
    chk("t5_post_empty", 32'(ifc.empty), 32'h1);

    // 300 overflow events, five distinct pushes each.
    a = 28'h100;
    for (int k = 1; k <= 300; k++) begin
      for (int j = 0; j < 5; j++) begin
        drive(1'b1, a, 2'b00);
        a = a + 28'd1;
      end
      if (k == 254) chk("t6_ovf254", 32'(ifc.overflow_count), 32'd254);
    end
    chk("t6_ovf_sat", 32'(ifc.overflow_count), 32'd255);
    chk("t6_flush", 32'(ifc.cons_flush_all), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
